// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time controller for the clock-divider datapath. Produces a divide-by-N
//   clock-enable tick and a near-50% divided square wave from clk. Ratio
//   changes arrive over a level req / pulse ack handshake and take effect only
//   at a period boundary, so consumers never see a runt period.
//
// Parameters
//   CNT_W        width of the divide ratio and the period counter
//   DEFAULT_DIV  ratio loaded at reset (1 .. 2^CNT_W-1)
//
// Ports
//   clk      in   clock, everything on posedge
//   reset    in   synchronous, active-high
//   en       in   1 = run; 0 = stop at the next period boundary
//   div_req  in   ratio-change request, held until div_ack
//   div_val  in   requested ratio, stable while div_req=1
//   div_ack  out  one-cycle pulse: request applied or rejected
//   div_err  out  one-cycle pulse with div_ack: request rejected (ratio 0)
//   tick     out  one-cycle pulse once per period
//   div_out  out  divided square wave, high for ceil(N/2) cycles
//   cur_div  out  ratio currently in effect
//   busy     out  divider is running (state != STOP)
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             tick,
    output logic             div_out,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [1:0] ST_STOP   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    // Length of the high phase: ceil(n/2), computed one bit wider so n=max
    // does not overflow.
    function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
        logic [CNT_W:0] t;
        t = {1'b0, n} + (CNT_W+1)'(1);
        return t[CNT_W:1];
    endfunction

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_tick;
    logic             r_div_out;
    logic             r_ack;
    logic             r_err;

    logic [1:0]       w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_cur_n;
    logic [CNT_W-1:0] w_pend_n;
    logic             w_tick_n;
    logic             w_ack_n;
    logic             w_err_n;
    logic             w_dout_n;
    logic             w_bound;
    logic             w_take;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cur_n   = r_cur_div;
        w_pend_n  = r_pend;
        w_tick_n  = 1'b0;
        w_ack_n   = 1'b0;
        w_err_n   = 1'b0;

        w_bound = (r_state != ST_STOP) && (r_cnt == (r_cur_div - CNT_W'(1)));
        // The cycle after an ack is skipped so a requester still dropping
        // div_req is not sampled a second time.
        w_take  = div_req && !r_ack && (r_state != ST_SWITCH);

        case (r_state)
            ST_STOP: begin
                w_cnt_n = '0;
                if (w_take) begin
                    w_ack_n = 1'b1;
                    if (div_val == '0) w_err_n = 1'b1;
                    else               w_cur_n = div_val;
                end
                if (en) w_state_n = ST_RUN;
            end
            ST_RUN: begin
                if (w_bound) begin
                    w_cnt_n  = '0;
                    w_tick_n = 1'b1;
                    if (!en) w_state_n = ST_STOP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
                // A request arriving as the divider stops is left for STOP.
                if (w_take && !(w_bound && !en)) begin
                    if (div_val == '0) begin
                        w_ack_n = 1'b1;
                        w_err_n = 1'b1;
                    end else begin
                        w_pend_n  = div_val;
                        w_state_n = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                if (w_bound) begin
                    w_cnt_n   = '0;
                    w_tick_n  = 1'b1;
                    w_cur_n   = r_pend;
                    w_ack_n   = 1'b1;
                    w_state_n = en ? ST_RUN : ST_STOP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_STOP;
                w_cnt_n   = '0;
            end
        endcase

        // div_out is derived from the next count so it lines up with cnt.
        w_dout_n = (w_state_n != ST_STOP) && (w_cnt_n < high_len(w_cur_n));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_cur_div <= CNT_W'(DEFAULT_DIV);
            r_tick    <= 1'b0;
            r_div_out <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_cur_div <= w_cur_n;
            r_tick    <= w_tick_n;
            r_div_out <= w_dout_n;
            r_ack     <= w_ack_n;
            r_err     <= w_err_n;
        end
    end

    // Pending ratio is only read in SWITCH, after it has been written.
    always_ff @(posedge clk) begin
        r_pend <= w_pend_n;
    end

    assign div_ack = r_ack;
    assign div_err = r_err;
    assign tick    = r_tick;
    assign div_out = r_div_out;
    assign cur_div = r_cur_div;
    assign busy    = (r_state != ST_STOP);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//   Self-checking bench for clk_div_ctrl. Expected tick and ack cycles are
//   queued when stimulus is applied; a negedge monitor pops and compares them
//   as the DUT produces ticks/acks.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             tick;
    logic             div_out;
    logic [CNT_W-1:0] cur_div;
    logic             busy;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .tick    (tick),
        .div_out (div_out),
        .cur_div (cur_div),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int e;
    } ack_t;

    int   tick_q[$];
    ack_t ack_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_ack(input int c, input int e);
        ack_t a;
        a.c = c;
        a.e = e;
        ack_q.push_back(a);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (tick) begin
                if (tick_q.size() == 0) chk("tick_unexpected", tick, 0);
                else chk("tick_cycle", cyc, tick_q.pop_front());
            end
            if (div_ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", div_ack, 0);
                else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    chk("ack_cycle", cyc, a.c);
                    chk("ack_err", div_err, a.e);
                end
            end else if (div_err) begin
                chk("err_without_ack", div_err, 0);
            end
        end
    end

    int t0, a, b, c, d, e, f;

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_tick", tick, 0);
        chk("rst_div_out", div_out, 0);
        chk("rst_ack", div_ack, 0);
        chk("rst_err", div_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_div", cur_div, 2);

        // default ratio 2
        reset  = 1'b0;
        mon_on = 1'b1;
        t0 = cyc;
        en = 1'b1;
        for (int k = 0; k < 4; k++) tick_q.push_back(t0 + 3 + 2 * k);
        wait_until(t0 + 1); chk("n2_dout0", div_out, 1);
        wait_until(t0 + 2); chk("n2_dout1", div_out, 0);
        wait_until(t0 + 3); chk("n2_dout2", div_out, 1);
        wait_until(t0 + 4); chk("n2_dout3", div_out, 0);
        chk("n2_busy", busy, 1);
        wait_until(t0 + 8); en = 1'b0;
        wait_until(t0 + 10);
        chk("n2_stop_busy", busy, 0);
        chk("n2_stop_dout", div_out, 0);

        // ratio 5 loaded in STOP
        a = cyc;
        div_val = 8'd5; div_req = 1'b1;
        push_ack(a + 1, 0);
        wait_until(a + 1); chk("stop_load_cur", cur_div, 5);
        div_req = 1'b0;
        wait_until(a + 2);
        b = cyc;
        en = 1'b1;
        tick_q.push_back(b + 6);
        tick_q.push_back(b + 11);
        tick_q.push_back(b + 14);
        tick_q.push_back(b + 17);
        for (int i = 0; i < 5; i++) begin
            wait_until(b + 1 + i);
            chk($sformatf("n5_dout%0d", i), div_out, (i < 3) ? 1 : 0);
        end

        // switch 5 -> 3 requested at cnt=1
        wait_until(b + 7);
        div_val = 8'd3; div_req = 1'b1;
        push_ack(b + 11, 0);
        wait_until(b + 10); chk("sw_cur_before", cur_div, 5);
        wait_until(b + 11); chk("sw_cur_after", cur_div, 3);
        div_req = 1'b0;
        wait_until(b + 12); chk("n3_dout1", div_out, 1);
        wait_until(b + 13); chk("n3_dout2", div_out, 0);
        wait_until(b + 16); en = 1'b0;
        wait_until(b + 18); chk("n3_stop_busy", busy, 0);

        // ratio 4, then a rejected zero request while running
        c = cyc;
        div_val = 8'd4; div_req = 1'b1;
        push_ack(c + 1, 0);
        wait_until(c + 1); div_req = 1'b0;
        wait_until(c + 2);
        d = cyc;
        en = 1'b1;
        tick_q.push_back(d + 5);
        tick_q.push_back(d + 9);
        tick_q.push_back(d + 13);
        wait_until(d + 6);
        div_val = 8'd0; div_req = 1'b1;
        push_ack(d + 7, 1);
        wait_until(d + 7); div_req = 1'b0;
        wait_until(d + 8); chk("zero_req_cur", cur_div, 4);

        // en dropped at cnt=2: one more tick, then stopped
        wait_until(d + 11); en = 1'b0;
        wait_until(d + 12); chk("stop_busy_pending", busy, 1);
        wait_until(d + 14);
        chk("stop_busy", busy, 0);
        chk("stop_dout", div_out, 0);
        wait_until(d + 25);

        // reset while a 6 -> 2 switch is pending
        e = cyc;
        div_val = 8'd6; div_req = 1'b1;
        push_ack(e + 1, 0);
        wait_until(e + 1); div_req = 1'b0;
        wait_until(e + 2);
        f = cyc;
        en = 1'b1;
        tick_q.push_back(f + 7);
        wait_until(f + 8);
        div_val = 8'd2; div_req = 1'b1;
        wait_until(f + 10);
        chk("sw6_cur_pending", cur_div, 6);
        chk("sw6_busy", busy, 1);
        reset = 1'b1;
        wait_until(f + 11);
        div_req = 1'b0; en = 1'b0;
        chk("rst_sw_cur", cur_div, 2);
        chk("rst_sw_busy", busy, 0);
        chk("rst_sw_dout", div_out, 0);
        wait_until(f + 12); reset = 1'b0;
        wait_until(f + 30);

        chk("ticks_outstanding", tick_q.size(), 0);
        chk("acks_outstanding", ack_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
